// File: rtl/packet_parser.sv
// packet_parser: splits framed 32-bit packet words into length-prefixed messages, one 296-bit record each.
module packet_parser (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [31:0]  dataIn,
  input  logic         dataIn_val,
  output logic         dataIn_ready,
  input  logic         dataIN_last,
  output logic [0:295] dataOut,
  output logic         dataOut_val,
  input  logic         dataOut_ready,
  output logic         packetLost
);
  typedef enum logic [1:0] {LEN, PAYLOAD, DISCARD} state_t;
  state_t state, stateNext;
  logic [31:0] bufWord, seq;
  logic [2:0] cnt;
  logic lastFlag;
  logic [7:0] len, lenNext, cur;
  logic [5:0] idx, idxNext;
  logic [0:255] payload, payNext;
  logic [0:295] rec;
  logic loadable, completes, consume, endPkt, load, lostNext;
  assign cur = bufWord[31:24];
  assign dataIn_ready = cnt == 3'd0 && !reset_b;
  assign loadable = !dataOut_val || dataOut_ready;
  assign completes = state == PAYLOAD && {2'b00, idx} + 8'd1 == len;
  // A completing byte waits in the buffer until the output register can take the record
  assign consume = cnt != 3'd0 && (!completes || loadable);
  assign endPkt = consume && cnt == 3'd1 && lastFlag;
  assign load = consume && completes;
  always_comb begin
    stateNext = state;
    lenNext = len;
    idxNext = idx;
    payNext = payload;
    lostNext = 1'b0;
    if (consume) begin
      case (state)
        LEN: begin
          if (cur > 8'd32) begin
            lostNext = 1'b1;
            stateNext = DISCARD;
          end else if (cur != 8'd0) begin
            lenNext = cur;
            idxNext = 6'd0;
            payNext = '0;
            stateNext = PAYLOAD;
          end
        end
        PAYLOAD: begin
          payNext[{idx[4:0], 3'b000} +: 8] = cur;
          idxNext = idx + 6'd1;
          stateNext = completes ? LEN : PAYLOAD;
        end
        default: stateNext = DISCARD;
      endcase
    end
    rec = {seq, len, payNext};
    if (endPkt) begin
      lostNext = lostNext || (state == PAYLOAD && !completes);
      stateNext = LEN;
      payNext = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state <= LEN;
      bufWord <= '0;
      cnt <= '0;
      lastFlag <= 1'b0;
      len <= '0;
      idx <= '0;
      payload <= '0;
      seq <= '0;
      dataOut <= '0;
      dataOut_val <= 1'b0;
      packetLost <= 1'b0;
    end else begin
      if (dataIn_val && dataIn_ready) begin
        bufWord <= dataIn;
        cnt <= 3'd4;
        lastFlag <= dataIN_last;
      end else if (consume) begin
        bufWord <= bufWord << 8;
        cnt <= cnt - 3'd1;
      end
      state <= stateNext;
      len <= lenNext;
      idx <= idxNext;
      payload <= payNext;
      packetLost <= lostNext;
      if (load) begin
        dataOut <= rec;
        dataOut_val <= 1'b1;
        seq <= seq + 32'd1;
      end else if (dataOut_ready) begin
        dataOut_val <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_packet_parser.sv
// tb_packet_parser: directed self-checking bench for packet_parser.
module tb_packet_parser;
  logic clk = 1'b0;
  logic reset_b, dataIn_val, dataIn_ready, dataIN_last, dataOut_val, dataOut_ready, packetLost;
  logic [31:0] dataIn;
  logic [0:295] dataOut;
  int checks = 0, errors = 0, lostCnt = 0, lost0, recs0;
  logic [295:0] recs[$];
  logic [5:0] pat;

  packet_parser dut (
    .clk(clk), .reset_b(reset_b), .dataIn(dataIn), .dataIn_val(dataIn_val),
    .dataIn_ready(dataIn_ready), .dataIN_last(dataIN_last), .dataOut(dataOut),
    .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready), .packetLost(packetLost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (packetLost) lostCnt++;
    if (dataOut_val && dataOut_ready) recs.push_back(dataOut);
  end

  function automatic logic [295:0] mk(input logic [31:0] s, input logic [7:0] l, input logic [255:0] p);
    return {s, l, p};
  endfunction

  task automatic check(input string tag, input logic [295:0] obs, input logic [295:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input logic l);
    int n = 0;
    while (!dataIn_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 296'(dataIn_ready), 296'd1);
    dataIn = w;
    dataIN_last = l;
    dataIn_val = 1'b1;
    @(posedge clk); #1;
    dataIn_val = 1'b0;
    dataIN_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b1; dataIn = '0; dataIn_val = 1'b0; dataIN_last = 1'b0; dataOut_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dataOut", 296'(dataOut), 296'd0);
    check("rst_val", 296'(dataOut_val), 296'd0);
    check("rst_lost", 296'(packetLost), 296'd0);
    check("rst_ready", 296'(dataIn_ready), 296'd0);
    @(posedge clk); #1 reset_b = 1'b0;

    // single message with trailing padding
    sendWord(32'h02AABB00, 1'b1);
    repeat (8) @(negedge clk);
    check("single_count", 296'(recs.size()), 296'd1);
    check("single_rec", recs[0], mk(0, 2, {8'hAA, 8'hBB, 240'h0}));
    check("single_lost", 296'(lostCnt), 296'd0);

    // message spanning two words, record two edges after second acceptance
    sendWord(32'h05010203, 1'b0);
    sendWord(32'h04050000, 1'b1);
    @(negedge clk); check("span_val_e0", 296'(dataOut_val), 296'd0);
    @(negedge clk); check("span_val_e1", 296'(dataOut_val), 296'd0);
    @(negedge clk); check("span_val_e2", 296'(dataOut_val), 296'd1);
    check("span_rec", 296'(dataOut), mk(1, 5, {40'h0102030405, 216'h0}));
    repeat (6) @(negedge clk);

    // truncated message: pulse after byte 3 consumed, no sequence used
    recs0 = recs.size();
    lost0 = lostCnt;
    sendWord(32'h04111213, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = packetLost;
    end
    check("trunc_pulse", 296'(pat), 296'(6'b010000));
    check("trunc_norec", 296'(recs.size()), 296'(recs0));
    sendWord(32'h01CC0000, 1'b1);
    repeat (8) @(negedge clk);
    check("trunc_next", recs[recs.size()-1], mk(2, 1, {8'hCC, 248'h0}));

    // bad length: pulse at length byte, packet discarded
    recs0 = recs.size();
    sendWord(32'h21000000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = packetLost;
    end
    check("bad_pulse", 296'(pat), 296'(6'b000010));
    sendWord(32'h01020304, 1'b1);
    repeat (8) @(negedge clk);
    check("bad_norec", 296'(recs.size()), 296'(recs0));
    check("bad_lost_total", 296'(lostCnt), 296'(lost0 + 2));
    sendWord(32'h01DD0000, 1'b1);
    repeat (8) @(negedge clk);
    check("bad_next", recs[recs.size()-1], mk(3, 1, {8'hDD, 248'h0}));

    // backpressure: first record held, second byte stalls, back-to-back load
    dataOut_ready = 1'b0;
    sendWord(32'h01AA01BB, 1'b1);
    repeat (6) @(negedge clk);
    check("bp_val", 296'(dataOut_val), 296'd1);
    check("bp_rec", 296'(dataOut), mk(4, 1, {8'hAA, 248'h0}));
    check("bp_in_ready", 296'(dataIn_ready), 296'd0);
    repeat (3) @(negedge clk);
    check("bp_hold", 296'(dataOut), mk(4, 1, {8'hAA, 248'h0}));
    @(posedge clk); #1 dataOut_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_b2b_val", 296'(dataOut_val), 296'd1);
    check("bp_b2b_rec", 296'(dataOut), mk(5, 1, {8'hBB, 248'h0}));
    @(negedge clk);
    check("bp_val_clear", 296'(dataOut_val), 296'd0);
    check("bp_count", 296'(recs.size()), 296'd6);
    check("bp_first", recs[4], mk(4, 1, {8'hAA, 248'h0}));
    check("bp_lost", 296'(lostCnt), 296'(lost0 + 2));

    // reset during PAYLOAD: silent, outputs cleared, sequence restarts
    sendWord(32'h05010203, 1'b0);
    @(posedge clk); #1 reset_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_dataOut", 296'(dataOut), 296'd0);
    check("mid_rst_val", 296'(dataOut_val), 296'd0);
    check("mid_rst_ready", 296'(dataIn_ready), 296'd0);
    @(posedge clk); #1 reset_b = 1'b0;
    sendWord(32'h01EE0000, 1'b1);
    repeat (8) @(negedge clk);
    check("mid_rst_seq", recs[recs.size()-1], mk(0, 1, {8'hEE, 248'h0}));
    check("mid_rst_lost", 296'(lostCnt), 296'(lost0 + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_parser.md
# packet_parser

Byte-stream message extractor between the 32-bit ingress bus and the 296-bit record consumer. It receives packets as framed 32-bit words and splits each packet's byte stream into length-prefixed messages. It emits one 296-bit record per complete message, carrying a sequence number, the length and the payload. Malformed or truncated messages are dropped and flagged on `packetLost`.

## Interface
Parameters: none; all widths are fixed.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_b`  in  1  synchronous reset, active-high. The name is kept as the codebase uses it; polarity is high.
- `dataIn`  in  32  ingress word; byte 0 = `dataIn[31:24]` … byte 3 = `dataIn[7:0]`.
- `dataIn_val`  in  1  ingress word valid.
- `dataIn_ready`  out  1  parser can accept a word.
- `dataIN_last`  in  1  qualifies `dataIn`: final word of the packet.
- `dataOut`  out  296, declared `[0:295]`  record:
  - `[0:31]` sequence number.
  - `[32:39]` length L.
  - `[40:295]` payload; byte k at `[40+8k : 47+8k]`, left-aligned, unused bytes zero.
- `dataOut_val`  out  1  record valid.
- `dataOut_ready`  in  1  consumer accepts the record.
- `packetLost`  out  1  one-cycle pulse when a message is dropped.

## Operation
- **Input buffer.** A word is accepted on an edge where `dataIn_val & dataIn_ready` is high. It is stored in a 4-byte buffer with a byte count (4) and the `last` flag.
- **Input ready.** `dataIn_ready` = buffer count is 0 and reset is not active.
- **Byte rate.** One byte is consumed per cycle, byte 0 first, unless the parser is stalled.
- **State LEN.**
  - Byte 0x00 is padding: skip it, stay in LEN.
  - Byte 1..32: latch L, clear the payload register, byte index := 0, go to PAYLOAD.
  - Byte >32: pulse `packetLost`, go to DISCARD.
- **State PAYLOAD.**
  - Write the byte at the current index, then index++.
  - When index reaches L the message is complete. Load the record {seq, L, payload} into the output register, increment seq (32-bit, wraps), go to LEN.
- **State DISCARD.** Consume and ignore bytes until the packet ends.
- **Packet end.** Packet end is the consumption of the final byte of a word whose `last` flag is set.
  - If the state at that point is PAYLOAD with an incomplete message, pulse `packetLost`.
  - In all cases, return to LEN with the partial payload cleared.
  - If the final byte itself completes the message, the record is emitted normally and there is no loss.
- **Output register.** The output register is loadable when `!dataOut_val`, or when `dataOut_ready` is high in the same cycle (back-to-back, no bubble).
- **Stall.** If a byte would complete a message while the register is not loadable, that byte is not consumed. The parser holds until the register becomes loadable.
- **Output hold.** `dataOut` and `dataOut_val` stay stable while `dataOut_val & !dataOut_ready`. `dataOut_val` clears on acceptance unless a new record loads on that same edge.
- **Sequence counter.** Lost messages do not consume sequence numbers.

## Timing
- **Reset values** (on the edge where `reset_b` = 1):
  - `dataOut` = 0, `dataOut_val` = 0, `packetLost` = 0, `dataIn_ready` = 0.
  - seq = 0, state = LEN, buffer empty.
- **Reset mid-packet.** Any partial message is discarded silently, with no `packetLost` pulse.
- **Word cadence.** A word accepted at edge N has its bytes consumed at edges N+1..N+4 when there is no stall. `dataIn_ready` is high after edge N+4, so the next acceptance is at edge N+5. Maximum rate is one word per 5 cycles.
- **Record latency.** `dataOut_val` rises on the edge that consumes the final payload byte.
- **`packetLost` timing.** It is asserted for exactly the cycle following the detecting edge.
- **Coincident events.** A record load and a `packetLost` pulse may coincide; both take effect.
- **Ignored input.** `dataIN_last` on an unaccepted word is ignored.

## Test plan
- **Single message.** Word 0x02AABB00 with last=1, `dataOut_ready`=1. Expect one record: seq=0, L=2, payload bytes AA, BB, rest zero. Expect no `packetLost`.
- **Message spanning words.** Words 0x05010203 then 0x0405_0000 with last on the second. Expect record L=5, payload 01..05, seq=0, emitted 2 cycles after the second word is accepted.
- **Truncated message.** Word 0x04111213 with last=1. Expect no record and a one-cycle `packetLost` after byte 3 is consumed. The next packet's record has seq=0.
- **Bad length.** Word 0x21000000 (L=33), then a second word with last. Expect a `packetLost` pulse at the length byte, remaining bytes ignored, and no record.
- **Backpressure.** `dataOut_ready`=0 with two one-byte messages 0x01AA01BB. Expect the first record held stable, the parser stalled on BB, and `dataIn_ready` low. When ready rises, the BB record (seq=1) loads on the same edge the first record is accepted.
- **Reset mid-packet.** Assert `reset_b` during PAYLOAD. Expect all outputs 0, no pulse, and seq restarting at 0.
